hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline control block for the 5-stage RV32 core. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Detects load-use hazards, EX-stage redirects (taken branch/jump) and variable-latency data-memory waits.
- Contains a memory-wait FSM with timeout, plus saturating stall and flush performance counters.

Parameters:
REG_IDX_WIDTH, 5, register index width
CNT_WIDTH, 32, performance counter width
MEM_TIMEOUT, 255, consecutive memory-stall cycles before fatal error (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
id_rs1  in  REG_IDX_WIDTH  rs1 index of instruction in ID
id_rs2  in  REG_IDX_WIDTH  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  ID/EX memRead (load in EX)
ex_rd  in  REG_IDX_WIDTH  ID/EX writeAddr
ex_redirect  in  1  taken branch/jump resolved in EX
mem_access  in  1  EX/MEM memRead|memWrite
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID flush (effective only with ifid_en=1)
idex_flush  out  1  ID/EX flush (insert bubble)
pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB (their enable = !pipe_hold)
mem_timeout_err  out  1  sticky fatal memory timeout
stall_cnt  out  CNT_WIDTH  cycles with pc_en=0, excluding M_ERR
flush_cnt  out  CNT_WIDTH  cycles in which a redirect flush took effect

Behaviour:
- All control outputs are combinational from inputs and state (0-cycle latency). Counters, FSM state and mem_timeout_err are registered.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mem_stall = mem_access & !dmem_ready, evaluated in M_IDLE/M_WAIT.
- Priority, highest first:
  - M_ERR: pc_en=0, ifid_en=0, pipe_hold=1, flushes 0.
  - mem_stall: same outputs as M_ERR. ex_redirect and load_use are ignored; EX is frozen, so they are re-presented later.
  - ex_redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, pipe_hold=0.
  - load_use: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0, pipe_hold=0. Lasts exactly one cycle, because the bubble clears ex_mem_read.
  - otherwise: pc_en=1, ifid_en=1, flushes 0, pipe_hold=0.
- FSM states M_IDLE, M_WAIT, M_ERR; to_cnt is $clog2(MEM_TIMEOUT+1) bits wide.
  - M_IDLE: if mem_stall, to_cnt<=1 and go to M_WAIT; if MEM_TIMEOUT==1, go to M_ERR directly.
  - M_WAIT: if !mem_stall, go to M_IDLE with to_cnt<=0. Else to_cnt<=to_cnt+1; when to_cnt+1==MEM_TIMEOUT, go to M_ERR and set mem_timeout_err.
  - M_ERR: absorbing until reset; dmem_ready has no effect.
  - Net effect: error is raised on the edge ending the MEM_TIMEOUT-th consecutive stalled cycle.
- Counters:
  - stall_cnt +1 on each edge where pc_en=0 and state!=M_ERR.
  - flush_cnt +1 on each edge where the ex_redirect branch of the priority is selected.
  - Both saturate at all-ones; no wrap.
- Reset (async, immediate): state=M_IDLE, to_cnt=0, mem_timeout_err=0, stall_cnt=0, flush_cnt=0. Control outputs then follow the priority rules from inputs.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1. Repeat with ex_rd=0 -> no stall. Repeat with id_use_rs1=0 -> no stall.
- Load-use and ex_redirect asserted together -> pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; flush_cnt +1, stall_cnt unchanged.
- mem_access=1, dmem_ready=0 for 3 cycles then 1, with ex_redirect=1 throughout -> pipe_hold=1 and pc_en=0 for 3 cycles, no flushes; 4th cycle redirect takes effect; stall_cnt=3, FSM back to M_IDLE.
- MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout_err=1 after 4th stalled edge; outputs frozen; later dmem_ready=1 has no effect; stall_cnt stays 4.
- Async reset pulse mid-M_WAIT between clock edges -> counters, to_cnt and mem_timeout_err clear immediately; state M_IDLE.
- CNT_WIDTH=4, 20 consecutive load-use cycles -> stall_cnt=15, no wrap.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline control for the 5-stage RV32 core. It detects load-use hazards,
// EX-stage redirects and data-memory waits, and drives the pipeline-register
// enables/flushes and the PC enable. A small FSM watches memory waits and
// raises a sticky fatal error when a single access is stalled too long.
// Saturating counters record stall cycles and effective redirect flushes.
module hazard_stall_ctrl #(
    parameter int REG_IDX_WIDTH = 5,
    parameter int CNT_WIDTH     = 32,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REG_IDX_WIDTH-1:0] id_rs1,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic                     ex_mem_read,
    input  logic [REG_IDX_WIDTH-1:0] ex_rd,
    input  logic                     ex_redirect,
    input  logic                     mem_access,
    input  logic                     dmem_ready,
    output logic                     pc_en,
    output logic                     ifid_en,
    output logic                     ifid_flush,
    output logic                     idex_flush,
    output logic                     pipe_hold,
    output logic                     mem_timeout_err,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
);

    // Wide enough to hold MEM_TIMEOUT itself, so the terminal compare never wraps.
    localparam int TO_WIDTH = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WAIT = 2'd1,
        M_ERR  = 2'd2
    } memState_t;

    memState_t           memState;
    logic [TO_WIDTH-1:0] toCnt;
    logic [TO_WIDTH-1:0] toCntInc;
    logic                inErr;
    logic                loadUse;
    logic                memStall;
    logic                redirectSel;

    assign inErr    = (memState == M_ERR);
    assign toCntInc = toCnt + 1'b1;

    // A load in EX whose destination is read by the instruction in ID; x0 never hazards.
    assign loadUse = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

    // Memory stall is only meaningful while the FSM is still alive.
    assign memStall = mem_access && !dmem_ready && !inErr;

    // Redirect wins only when nothing freezes the pipe; this is also what flush_cnt counts.
    assign redirectSel = !inErr && !memStall && ex_redirect;

    // Priority decode of the pipeline control outputs (error > mem stall > redirect > load-use).
    always_comb begin
        // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (inErr || memStall) begin
            // EX is frozen, so any redirect or load-use is re-presented once memory completes.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            pipe_hold = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (loadUse) begin
            // The bubble clears ex_mem_read, so this lasts exactly one cycle.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Memory-wait FSM: counts consecutive stalled cycles and latches a fatal timeout.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
        if (reset) begin
            memState        <= M_IDLE;
            toCnt           <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (memState)
                M_IDLE: begin
                    if (memStall) begin
                        toCnt <= TO_WIDTH'(1);
                        if (MEM_TIMEOUT == 1) begin
                            memState        <= M_ERR;
                            mem_timeout_err <= 1'b1;
                        end else begin
                            memState <= M_WAIT;
                        end
                    end
                end
                M_WAIT: begin
                    if (!memStall) begin
                        memState <= M_IDLE;
                        toCnt    <= '0;
                    end else begin
                        toCnt <= toCntInc;
                        if (toCntInc == TO_WIDTH'(MEM_TIMEOUT)) begin
                            memState        <= M_ERR;
                            mem_timeout_err <= 1'b1;
                        end
                    end
                end
                M_ERR: begin
                    // Absorbing until reset; dmem_ready is deliberately ignored here.
                    memState <= M_ERR;
                end
                default: begin
                    memState <= M_IDLE;
                    toCnt    <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters: stalled cycles (outside M_ERR) and effective redirect flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && !inErr && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (redirectSel && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed scenarios plus randomized traffic, checked against a behavioural
// model that tracks the consecutive-stall run length and counters as integers.
module tb_hazard_stall_ctrl;

    localparam int RIW     = 5;
    localparam int CW      = 4;
    localparam int MT      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic           clk;
    logic           reset;
    logic [RIW-1:0] id_rs1;
    logic [RIW-1:0] id_rs2;
    logic           id_use_rs1;
    logic           id_use_rs2;
    logic           ex_mem_read;
    logic [RIW-1:0] ex_rd;
    logic           ex_redirect;
    logic           mem_access;
    logic           dmem_ready;
    logic           pc_en;
    logic           ifid_en;
    logic           ifid_flush;
    logic           idex_flush;
    logic           pipe_hold;
    logic           mem_timeout_err;
    logic [CW-1:0]  stall_cnt;
    logic [CW-1:0]  flush_cnt;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model state
    int mRun;
    bit mErr;
    int mStall;
    int mFlush;

    hazard_stall_ctrl #(
        .REG_IDX_WIDTH(RIW),
        .CNT_WIDTH    (CW),
        .MEM_TIMEOUT  (MT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_redirect    (ex_redirect),
        .mem_access     (mem_access),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .pipe_hold      (pipe_hold),
        .mem_timeout_err(mem_timeout_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mRun   = 0;
        mErr   = 1'b0;
        mStall = 0;
        mFlush = 0;
    endtask

    task automatic setIdle();
        id_rs1      = '0;
        id_rs2      = '0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = '0;
        ex_redirect = 1'b0;
        mem_access  = 1'b0;
        dmem_ready  = 1'b1;
    endtask

    // Called shortly after a negedge with inputs applied; returns at the next negedge.
    task automatic cycle(input string tag);
        bit lu, ms, sel;
        bit ePc, eIfid, eIff, eIdf, eHold;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        ms = !mErr && mem_access && !dmem_ready;
        {ePc, eIfid, eIff, eIdf, eHold} = 5'b11000;
        sel = 1'b0;
        if (mErr || ms) begin
            {ePc, eIfid, eIff, eIdf, eHold} = 5'b00001;
        end else if (ex_redirect) begin
            {ePc, eIfid, eIff, eIdf, eHold} = 5'b11110;
            sel = 1'b1;
        end else if (lu) begin
            {ePc, eIfid, eIff, eIdf, eHold} = 5'b00010;
        end
        #1;
        check({tag, ".ctl"}, {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold},
              {27'd0, ePc, eIfid, eIff, eIdf, eHold});
        @(posedge clk);
        if (!ePc && !mErr && mStall < CNT_MAX) mStall++;
        if (sel && mFlush < CNT_MAX) mFlush++;
        if (ms) begin
            mRun++;
            if (mRun >= MT) mErr = 1'b1;
        end else if (!mErr) begin
            mRun = 0;
        end
        #1;
        check({tag, ".err"}, 32'(mem_timeout_err), 32'(mErr));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mStall));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(mFlush));
        @(negedge clk);
    endtask

    // Pulse reset between edges and check the immediate clear while it is held.
    task automatic doReset(input string tag);
        reset = 1'b1;
        #2;
        modelReset();
        check({tag, ".rst_stall"}, 32'(stall_cnt), 32'd0);
        check({tag, ".rst_flush"}, 32'(flush_cnt), 32'd0);
        check({tag, ".rst_err"}, 32'(mem_timeout_err), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        setIdle();
        modelReset();
        reset = 1'b1;
        #3;
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);
        check("reset.err", 32'(mem_timeout_err), 32'd0);
        check("reset.ctl", {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold}, 32'b11000);
        @(negedge clk);
        reset = 1'b0;

        // Load-use on rs1, then the bubble clears it
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cycle("lu_rs1");
        check("lu_rs1.stall1", 32'(stall_cnt), 32'd1);
        ex_mem_read = 1'b0;
        cycle("lu_bubble");
        // x0 destination never hazards
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        cycle("lu_x0");
        // Matching index but operand not used
        ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
        cycle("lu_nouse");
        // Hazard through rs2
        id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        cycle("lu_rs2");
        // Load-use together with redirect: redirect wins
        id_use_rs1 = 1'b1; ex_redirect = 1'b1;
        cycle("lu_redir");
        check("lu_redir.flush", 32'(flush_cnt), 32'd1);
        check("lu_redir.stall", 32'(stall_cnt), 32'd2);
        setIdle();

        // Memory stall 3 cycles with redirect held, then completion
        doReset("mw");
        mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) cycle("mw_stall");
        dmem_ready = 1'b1;
        cycle("mw_done");
        check("mw.stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw.flush_cnt", 32'(flush_cnt), 32'd1);
        setIdle();
        // Back in M_IDLE: a fresh 3-cycle stall must not reach the timeout
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mw_again");
        setIdle();
        cycle("mw_idle");
        check("mw.no_err", 32'(mem_timeout_err), 32'd0);

        // Timeout: error after the MT-th stalled edge, then frozen
        doReset("to");
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MT + 2; i++) cycle("to_stall");
        check("to.err", 32'(mem_timeout_err), 32'd1);
        check("to.stall_cnt", 32'(stall_cnt), 32'(MT));
        dmem_ready = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) cycle("to_frozen");
        check("to.frozen_stall", 32'(stall_cnt), 32'(MT));
        setIdle();

        // Async reset in the middle of M_WAIT
        doReset("ar0");
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) cycle("ar_stall");
        doReset("ar");
        for (int i = 0; i < MT - 1; i++) cycle("ar_restart");
        check("ar.no_err", 32'(mem_timeout_err), 32'd0);
        setIdle();

        // Saturation of the stall counter
        doReset("sat");
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        for (int i = 0; i < 20; i++) cycle("sat_lu");
        check("sat.stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        setIdle();

        // Randomized traffic
        doReset("rnd0");
        for (int n = 0; n < 3000; n++) begin
            id_rs1      = RIW'($urandom_range(0, 3));
            id_rs2      = RIW'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            ex_mem_read = ($urandom_range(0, 99) < 40);
            ex_rd       = RIW'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 99) < 20);
            mem_access  = ($urandom_range(0, 99) < 40);
            dmem_ready  = ($urandom_range(0, 99) < 50);
            if ($urandom_range(0, 99) == 0) doReset("rnd");
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
